// File: rtl/dmem_pkg.sv
// dmem_pkg: length encodings, FSM states and byte-count helper for dmem_sync
package dmem_pkg;
  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;
  typedef enum logic {CLEAR, READY} state_t;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == LEN_WORD ? 3'd4 : len == LEN_HALF ? 3'd2 : len == LEN_BYTE ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: DEPTH x 8 storage, four lanes at consecutive byte addresses
module dmem_byte_array #(
  parameter int DEPTH = 128,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                SYS_clk,
  input  logic [3:0]          we,
  input  logic [3:0][AW-1:0]  addr,
  input  logic [3:0][7:0]     wdata,
  output logic [3:0][7:0]     rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge SYS_clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr[i]] <= wdata[i];
  always_comb
    for (int i = 0; i < 4; i++)
      rdata[i] = mem[addr[i]];
endmodule

// File: rtl/dmem_sync.sv
// dmem_sync: big-endian byte-addressed data memory with registered response and zero-fill sweep
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int ADDR_W = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_length,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_fault,
  output logic              init_done
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [AW-1:0] cnt;
  logic [2:0] n;
  logic [ADDR_W:0] last;
  logic mis, fault, acc, act, s;
  logic [3:0] we;
  logic [3:0][AW-1:0] addr;
  logic [3:0][7:0] wd, rd;
  logic [31:0] wl, ld;
  dmem_byte_array #(.DEPTH(DEPTH), .AW(AW)) u_arr (
    .SYS_clk(SYS_clk), .we(we), .addr(addr), .wdata(wd), .rdata(rd)
  );
  always_comb begin
    n = len_bytes(req_length);
    // one extra bit so addresses near the top of the space cannot wrap into range
    last = {1'b0, req_addr} + (ADDR_W+1)'(n) - (ADDR_W+1)'(1);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (req_length == LEN_HALF && req_addr[0]) || (req_length == LEN_WORD && req_addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    fault = n != 3'd0 && (last >= (ADDR_W+1)'(DEPTH) || mis);
    acc = req_valid && req_ready;
    act = acc && !fault && n != 3'd0;
    wl = req_wdata << (6'd32 - {n, 3'b000});
    we = state == CLEAR ? 4'b0001 : act && req_write ? 4'b1111 >> (3'd4 - n) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      addr[i] = (state == CLEAR ? cnt : req_addr[AW-1:0]) + AW'(i);
      wd[i] = state == CLEAR ? 8'h00 : wl[31-8*i -: 8];
    end
    s = req_signed && rd[0][7];
    ld = n == 3'd4 ? {rd[0], rd[1], rd[2], rd[3]} :
         n == 3'd2 ? {{16{s}}, rd[0], rd[1]} : {{24{s}}, rd[0]};
  end
  always_ff @(posedge SYS_clk or negedge SYS_reset_n)
    if (!SYS_reset_n) begin
      state <= CLEAR;
      cnt <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_fault <= 1'b0;
      init_done <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(DEPTH-1)) begin
        state <= READY;
        req_ready <= 1'b1;
        init_done <= 1'b1;
      end
    end else begin
      rsp_valid <= acc;
      rsp_fault <= acc && fault;
      rsp_data <= act && !req_write ? ld : '0;
    end
endmodule

// File: doc/dmem_sync.md
# dmem_sync

Parametrised, byte-addressed, big-endian data memory for the RISC-V core's load/store path, replacing the combinational-read data memory. Accepts one load or store per cycle through a valid/ready request port and returns a registered response one cycle later, with sign/zero extension, fault reporting for out-of-range or misaligned accesses, and a hardware zero-fill sweep after reset.

## Interface
- DEPTH, 128: memory size in bytes; power of two, at least 4.
- ADDR_W, 32: request address width.
- SYS_clk  in  1  clock; all state changes on its rising edge.
- SYS_reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_length  in  2  00 none, 01 byte, 10 half-word, 11 word.
- req_signed  in  1  loads only: sign-extend byte/half.
- req_addr  in  ADDR_W  byte address of the most-significant byte.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_data  out  32  load result; 0 for stores, faults and length 00.
- rsp_fault  out  1  accepted request was not performed.
- init_done  out  1  zero-fill sweep complete.

## Operation
- FSM states: CLEAR, READY.
- Reset asserted: state=CLEAR, sweep counter=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_fault=0, init_done=0. Array contents are not reset asynchronously.
- CLEAR: writes 0x00 to byte[counter] each cycle and increments. After writing byte DEPTH-1, state goes to READY and init_done=1. req_ready=0 throughout.
- READY: req_ready=1 every cycle. No response backpressure.
- Byte order: byte[A] holds bits 31:24 of a word and 15:8 of a half-word.
- Store word writes byte[A..A+3] = wdata[31:24], [23:16], [15:8], [7:0]. Half-word writes byte[A..A+1] = wdata[15:8], [7:0]. Byte writes byte[A] = wdata[7:0].
- Load: byte/half results are zero-extended, or sign-extended from the MSB of byte[A] when req_signed=1. req_signed is ignored for words and stores.
- Length 00: no array access; response has data 0 and fault 0.
- Out of range: fault when A + N - 1 >= DEPTH, where N = 1/2/4 bytes.
  - Computed in ADDR_W+1 bits, so that 0xFFFF_FFFF + 3 does not wrap into range.
- Faulting request: no array write; rsp_fault=1, rsp_data=0.

## Timing
- Request accepted on edge T: store updates the array at T; rsp_valid=1 during cycle T+1 only.
- Load data is sampled from the array state after any write committed at an earlier edge. A load accepted at T+1 after a store at T returns the new data.
- rsp_valid is high for exactly one cycle per accepted request. Back-to-back requests give back-to-back pulses.
- Sweep length: DEPTH cycles from reset release to init_done=1. The first request can be accepted on the following edge.
- Reset mid-sweep: sweep aborts and restarts from 0 after release.
- Reset mid-response: outputs clear immediately. The in-flight response is lost.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: half-word with A[0]≠0, or word with A[1:0]≠0, faults with no array write.
- DMEM_MISALIGN_TRAP_EN undefined: misaligned accesses are performed byte-wise per the byte order rules. Only the range check applies.

## Structure
- Package dmem_pkg:
  - length encodings LEN_NONE / LEN_BYTE / LEN_HALF / LEN_WORD.
  - FSM state enum.
  - function returning N for a length code.
- Sub-module dmem_byte_array: DEPTH x 8 storage.
  - Four write ports with per-lane enables, for bytes at A..A+3.
  - Four combinational read ports.
  - No reset.
- Top level holds the FSM, sweep counter, fault logic, extension and response registers.

## Test plan
- Release reset, DEPTH=128 → init_done rises after 128 cycles; a word load at 0x7C returns 0x0000_0000 with fault 0.
- Store word 0x8899_AABB at 0x10, then load byte at 0x10 signed → 0xFFFF_FF88; then unsigned half at 0x12 → 0x0000_AABB.
- Store word at 0x7E → rsp_fault=1 and byte[0x7E] unchanged. Word load at addr 0xFFFF_FFFE → fault with no wrap.
- Store word at 0x21, then load word at 0x21:
  - macro defined: both requests fault.
  - macro undefined: load returns the stored word.
- Eight back-to-back stores and loads with req_valid held high → eight consecutive rsp_valid pulses; each load sees the previous cycle's store.
- Assert SYS_reset_n low at sweep cycle 60 → init_done stays 0; after release the sweep takes another 128 cycles.
